// File: rtl/mul3_pkg.sv
// mul3_pkg: shared types and sizing helpers for the multiply-by-3 recombiner
package mul3_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} mul3_state_t;
    localparam int CARRY_W = 2;
    function automatic int res_w(input int width);
        return width + 2;
    endfunction
endpackage

// File: rtl/mul3_bit.sv
// mul3_bit: one LSB-first step of 3*q + r, built from full-adder cells
module fullAdder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module mul3_bit
    import mul3_pkg::*;
(
    input  logic               qb,
    input  logic               prev,
    input  logic [CARRY_W-1:0] carry,
    output logic               sbit,
    output logic [CARRY_W-1:0] carry_next
);
    logic c0;
    // qb + prev + carry is at most 4, so the upper adder only folds c0 into carry[1]
    fullAdder u_lo (.a(qb), .b(prev), .cin(carry[0]), .s(sbit), .cout(c0));
    fullAdder u_hi (.a(c0), .b(carry[1]), .cin(1'b0), .s(carry_next[0]), .cout(carry_next[1]));
endmodule

// File: rtl/mul3_recombine_seq.sv
// mul3_recombine_seq: bit-serial x = 3*q + r with valid/ready handshakes
module mul3_recombine_seq
    import mul3_pkg::*;
#(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] q,
    input  logic [1:0]       r,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH+1:0] x,
    output logic             err
);
    localparam int RW = res_w(WIDTH);
    localparam int CW = $clog2(WIDTH + 2);
    mul3_state_t state, nxt;
    logic [WIDTH-1:0]   qsh;
    logic [CARRY_W-1:0] carry, cn;
    logic               prev, sbit, last;
    logic [CW-1:0]      cnt;
    logic [RW-1:0]      xsh;
    mul3_bit u_bit (.qb(qsh[0]), .prev(prev), .carry(carry), .sbit(sbit), .carry_next(cn));
    assign last      = cnt == CW'(WIDTH + 1);
    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;
    assign x         = xsh;
    always_comb begin
        nxt = state;
        if (state == IDLE && in_valid)
            nxt = (r == 2'd3) ? DONE : RUN;
        else if (state == RUN && last)
            nxt = DONE;
        else if (state == DONE && out_ready)
            nxt = IDLE;
    end
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= nxt;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            qsh   <= '0;
            carry <= '0;
            prev  <= 1'b0;
            cnt   <= '0;
            xsh   <= '0;
            err   <= 1'b0;
        end else if (state == IDLE && in_valid) begin
            qsh   <= q;
            carry <= r;
            prev  <= 1'b0;
            cnt   <= '0;
            xsh   <= '0;
            err   <= r == 2'd3;
        end else if (state == RUN) begin
            // result fits in WIDTH+2 bits, so nothing may carry out of the last step
            if (last)
                assert (cn == '0);
            xsh   <= {sbit, xsh[RW-1:1]};
            prev  <= qsh[0];
            qsh   <= qsh >> 1;
            carry <= cn;
            cnt   <= cnt + 1'b1;
        end
    end
endmodule

// File: doc/mul3_recombine_seq.md
# mul3_recombine_seq

Bit-serial sequential recombiner that reconstructs a dividend from a divide-by-3 result: given quotient `q` and remainder `r`, it produces `x = 3*q + r`. It is the inverse of the team's divide-by-3 datapath. It sits on the check/readback side of that datapath and lets a bench or a built-in self-check close the loop `x -> (q, r) -> x`. One result bit is computed per clock, LSB first, behind a valid/ready handshake on both sides.

## Interface
- `WIDTH`, default 6, is the quotient width in bits. The result width is `WIDTH+2`.
- `clk`  in  1  is the single clock. All state updates happen on its rising edge.
- `rst`  in  1  is a synchronous, active-high reset.
- `in_valid`  in  1  means the operands `q` and `r` are valid.
- `in_ready`  out  1  means the block accepts operands. It is high only in IDLE.
- `q`  in  `WIDTH`  is the quotient operand (unsigned).
- `r`  in  2  is the remainder operand. Legal values are 0..2.
- `out_valid`  out  1  means `x` and `err` are valid. It is high only in DONE.
- `out_ready`  in  1  means the consumer takes the result.
- `x`  out  `WIDTH+2`  is the result, `3*q + r`.
- `err`  out  1  flags an illegal remainder (`r == 3`) on the current result.

## Operation
- **States:** IDLE, RUN, DONE.
- **IDLE:**
  - `in_ready=1`.
  - When `in_valid && in_ready` at an edge, the block latches `qsh <= q`, `carry <= r`, `prev <= 0`, `cnt <= 0`, `xsh <= 0`.
  - If `r == 3`: set `err <= 1`, keep `xsh = 0`, go straight to DONE.
  - Otherwise: set `err <= 0` and go to RUN.
- **RUN:** each edge performs one step:
  - `t = qsh[0] + prev + carry` (3 bits, maximum 4).
  - `xsh <= {t[0], xsh[WIDTH+1:1]}`.
  - `prev <= qsh[0]`, `qsh <= qsh >> 1` (zero fill), `carry <= t[2:1]`, `cnt <= cnt + 1`.
  - Exit to DONE after the step where `cnt == WIDTH+1`. That makes exactly `WIDTH+2` steps.
- **Arithmetic invariants:**
  - `carry` is always in 0..2, so it is 2 bits wide.
  - Final carry is 0, since `3*(2^WIDTH-1)+2 < 2^(WIDTH+2)`. The design carries a simulation assertion on this.
  - `cnt` is `$clog2(WIDTH+2)` bits wide.
- **DONE:**
  - `out_valid=1`, `x = xsh`. Both `x` and `err` are held stable while `out_ready=0`.
  - When `out_valid && out_ready` at an edge, go to IDLE.
- **Reset values:** state=IDLE, `in_ready=1`, `out_valid=0`, `x=0`, `err=0`. All internal registers are 0.
- **Reset mid-operation:** any in-flight operation is aborted with no output. On the cycle after the `rst` edge, `out_valid=0` and `in_ready=1`.
- **Simultaneous events:**
  - `in_valid` during RUN or DONE is ignored; the producer must hold it.
  - There is no bypass from DONE to IDLE, so the cycle after the output handshake always has `in_ready=1`, `out_valid=0`.
  - `rst` overrides every handshake.

## Timing
- Let T be the edge where the input handshake occurs (legal `r`).
- RUN occupies edges T+1 .. T+WIDTH+2.
- `out_valid` is high starting at the cycle after edge T+WIDTH+2, i.e. WIDTH+2 cycles after the input handshake. With WIDTH=6 that is 8 cycles.
- For illegal `r`, `out_valid` is high the cycle after edge T.
- Minimum initiation interval is WIDTH+4 cycles, assuming immediate `out_ready` and back-to-back `in_valid`.
- All outputs are registered or decoded from state only. There is no combinational path from inputs to outputs.

## Structure
- **Package `mul3_pkg`** contains:
  - the state enum `mul3_state_t` (IDLE, RUN, DONE);
  - the constant `CARRY_W = 2`;
  - a function `res_w(width)` returning `width+2`.
- **Sub-module `mul3_bit`:** a combinational one-step cell.
  - Inputs: `qb`, `prev`, `carry[1:0]`.
  - Outputs: `sbit`, `carry_next[1:0]`.
  - Built from the team's `fullAdder` cells in the same style as the divider cell.
  - The top level instantiates it once and holds the FSM, shift registers and counter.

## Test plan
All scenarios use WIDTH=6.
- `q=21`, `r=2`, `out_ready=1` → `out_valid` rises 8 cycles after the handshake with `x=65`, `err=0`; `in_ready` returns to 1 one cycle later.
- `q=63`, `r=2` → `x=191` (8'b10111111), `err=0`; the final-carry assertion holds. Also `q=0`, `r=0` → `x=0`.
- `q=5`, `r=3` → `out_valid` the next cycle with `err=1`, `x=0`. A following legal op `q=5`, `r=1` gives `x=16`, `err=0`.
- Backpressure: `q=10`, `r=1`, `out_ready` held low for 5 cycles in DONE → `x=31` stays stable, `in_ready=0`, and an `in_valid` pulse in that window is ignored.
- Reset mid-RUN: assert `rst` 3 cycles after the handshake → next cycle `out_valid=0`, `in_ready=1`, `x=0`, and no result is ever produced for the aborted op.
- Exhaustive loop-back: for all `x` in 0..63, feed the 6-bit divide-by-3 datapath and pass its `(quotient, remainder)` into this block → the result equals `x` every time and `err` is never set.
